// File: rtl/ar_serial_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : ar_serial_accumulator
// Purpose  : Bit-serial 29-bit recirculating AR line with copy/add and end-carry.
// Revision : 1.0
// ============================================================================
module ar_serial_accumulator #(
    parameter int WORD_BITS = 29
) (
    input  logic CLOCK,
    input  logic rst,
    input  logic TS,
    input  logic IB,
    input  logic DV,
    input  logic AA,
    input  logic IS,
    input  logic CLR_AR,
    output logic EB_AR,
    output logic AR,
    output logic AC,
    output logic AR_OVF
);

    localparam int MAG_BITS = WORD_BITS - 1;
    localparam int CW       = $clog2(WORD_BITS);
    localparam logic [CW-1:0] LAST_BIT = CW'(WORD_BITS - 1);

    localparam logic [1:0] MODE_IDLE = 2'd0;
    localparam logic [1:0] MODE_COPY = 2'd1;
    localparam logic [1:0] MODE_ADD  = 2'd2;

    logic [MAG_BITS-1:0] mag;
    logic [CW-1:0]       cnt;
    logic [1:0]          mode;
    logic                sign;
    logic                carry;
    logic                op_sign;
    logic                old_sign;
    logic                pend;
    logic                pend_sign;
    logic                pend_ovf;
    logic                ovf_q;
    logic                ac_q;

    logic                is_ts;
    logic [CW-1:0]       pos;
    logic [1:0]          ts_mode;
    logic                commit;
    logic                sign_now;
    logic                sum;
    logic                carry_nx;
    logic                final_sign;

    // A missing TS is tolerated: a counter of zero marks the sign time by itself.
    always_comb begin
        is_ts      = TS | (cnt == '0);
        pos        = is_ts ? '0 : cnt;
        ts_mode    = !DV ? MODE_IDLE : (AA ? MODE_ADD : MODE_COPY);
        commit     = is_ts & pend & ~CLR_AR;
        sign_now   = commit ? pend_sign : sign;
        sum        = mag[0] ^ IB ^ carry;
        carry_nx   = (mag[0] & IB) | (mag[0] & carry) | (IB & carry);
        final_sign = old_sign ^ op_sign ^ carry_nx;
    end

    assign EB_AR  = is_ts ? sign_now : mag[0];
    assign AR     = sign_now;
    assign AC     = ac_q;
    assign AR_OVF = ovf_q | (commit & pend_ovf);

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            mag       <= '0;
            cnt       <= '0;
            mode      <= MODE_IDLE;
            sign      <= 1'b0;
            carry     <= 1'b0;
            op_sign   <= 1'b0;
            old_sign  <= 1'b0;
            pend      <= 1'b0;
            pend_sign <= 1'b0;
            pend_ovf  <= 1'b0;
            ovf_q     <= 1'b0;
            ac_q      <= 1'b0;
        end else begin
            cnt <= (pos == LAST_BIT) ? '0 : pos + 1'b1;

            if (is_ts) begin
                ovf_q <= commit & pend_ovf;
            end else if (pos == LAST_BIT) begin
                ovf_q <= 1'b0;
            end

            if (CLR_AR) begin
                // Dropping to IDLE also aborts any add so it can never commit.
                mode <= MODE_IDLE;
                pend <= 1'b0;
                ac_q <= 1'b0;
                if (is_ts) begin
                    sign <= 1'b0;
                end else begin
                    mag <= {1'b0, mag[MAG_BITS-1:1]};
                end
            end else if (is_ts) begin
                mode <= ts_mode;
                pend <= 1'b0;
                case (ts_mode)
                    MODE_COPY: begin
                        sign <= IB;
                        ac_q <= 1'b0;
                    end
                    MODE_ADD: begin
                        sign     <= sign_now;
                        op_sign  <= IB;
                        old_sign <= sign_now;
                        carry    <= IS;
                    end
                    default: sign <= sign_now;
                endcase
            end else begin
                case (mode)
                    MODE_COPY: mag <= {IB, mag[MAG_BITS-1:1]};
                    MODE_ADD: begin
                        mag   <= {sum, mag[MAG_BITS-1:1]};
                        carry <= carry_nx;
                        if (pos == LAST_BIT) begin
                            ac_q      <= carry_nx;
                            pend      <= 1'b1;
                            pend_sign <= final_sign;
                            pend_ovf  <= (old_sign == op_sign) && (final_sign != old_sign);
                        end
                    end
                    default: mag <= {mag[0], mag[MAG_BITS-1:1]};
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ar_serial_accumulator.sv
`default_nettype none
// Directed bench for ar_serial_accumulator: words are driven sign first, magnitude LSB first.
module tb_ar_serial_accumulator;

    logic CLOCK = 1'b0;
    logic rst, TS, IB, DV, AA, IS, CLR_AR;
    logic EB_AR, AR, AC, AR_OVF;

    int checks   = 0;
    int failures = 0;

    logic        cap_sign;
    logic [27:0] cap_mag;
    int          ovf_cnt;
    logic        ar_mid;

    ar_serial_accumulator #(.WORD_BITS(29)) dut (
        .CLOCK (CLOCK),
        .rst   (rst),
        .TS    (TS),
        .IB    (IB),
        .DV    (DV),
        .AA    (AA),
        .IS    (IS),
        .CLR_AR(CLR_AR),
        .EB_AR (EB_AR),
        .AR    (AR),
        .AC    (AC),
        .AR_OVF(AR_OVF)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one word (or its first ncyc bit times) and captures EB_AR/AR/AR_OVF.
    task automatic run_word(input logic use_ts, input logic sgn, input logic [27:0] mag,
                            input logic dv, input logic aa, input logic is_in,
                            input int aa_flip, input int clr_lo, input int clr_hi, input int ncyc);
        logic [27:0] sh;
        sh      = mag;
        ovf_cnt = 0;
        cap_mag = '0;
        for (int i = 0; i < ncyc; i++) begin
            TS = use_ts && (i == 0);
            if (i == 0) begin
                IB = sgn;
            end else begin
                IB = sh[0];
                sh = sh >> 1;
            end
            DV     = dv;
            AA     = (aa_flip >= 0 && i >= aa_flip) ? ~aa : aa;
            IS     = is_in;
            CLR_AR = (i >= clr_lo) && (i <= clr_hi);
            @(negedge CLOCK);
            if (i == 0) cap_sign = EB_AR;
            else        cap_mag  = {EB_AR, cap_mag[27:1]};
            if (AR_OVF) ovf_cnt++;
            if (i == 14) ar_mid = AR;
            @(posedge CLOCK);
            #1;
        end
        TS     = 1'b0;
        CLR_AR = 1'b0;
        DV     = 1'b0;
        AA     = 1'b0;
        IS     = 1'b0;
    endtask

    task automatic word(input logic use_ts, input logic sgn, input logic [27:0] mag,
                        input logic dv, input logic aa, input logic is_in);
        run_word(use_ts, sgn, mag, dv, aa, is_in, -1, 99, -1, 29);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; TS = 1'b0; IB = 1'b0; DV = 1'b0; AA = 1'b0; IS = 1'b0; CLR_AR = 1'b0;
        repeat (2) @(posedge CLOCK);
        #1;
        check("reset_AR", {31'd0, AR}, 32'd0);
        check("reset_AC", {31'd0, AC}, 32'd0);
        check("reset_OVF", {31'd0, AR_OVF}, 32'd0);
        check("reset_EB", {31'd0, EB_AR}, 32'd0);
        rst = 1'b0;

        // Copy
        word(1'b1, 1'b0, 28'h0ABCDEF, 1'b1, 1'b0, 1'b0);
        word(1'b1, 1'b0, 28'h0, 1'b0, 1'b0, 1'b0);
        check("copy_sign", {31'd0, cap_sign}, 32'd0);
        check("copy_mag", {4'd0, cap_mag}, 32'h0ABCDEF);
        check("copy_AC", {31'd0, AC}, 32'd0);

        // +5 + +3
        word(1'b1, 1'b0, 28'd5, 1'b1, 1'b0, 1'b0);
        word(1'b1, 1'b0, 28'd3, 1'b1, 1'b1, 1'b0);
        word(1'b1, 1'b0, 28'h0, 1'b0, 1'b0, 1'b0);
        check("addpos_mag", {4'd0, cap_mag}, 32'd8);
        check("addpos_sign", {31'd0, cap_sign}, 32'd0);
        check("addpos_AC", {31'd0, AC}, 32'd0);
        check("addpos_AR", {31'd0, ar_mid}, 32'd0);
        check("addpos_ovf", ovf_cnt, 32'd0);

        // +5 plus complemented 3 with carry-in
        word(1'b1, 1'b0, 28'd5, 1'b1, 1'b0, 1'b0);
        word(1'b1, 1'b1, 28'hFFFFFFC, 1'b1, 1'b1, 1'b1);
        word(1'b1, 1'b0, 28'h0, 1'b0, 1'b0, 1'b0);
        check("addcmp_mag", {4'd0, cap_mag}, 32'd2);
        check("addcmp_sign", {31'd0, cap_sign}, 32'd0);
        check("addcmp_AC", {31'd0, AC}, 32'd1);
        check("addcmp_AR", {31'd0, ar_mid}, 32'd0);

        // Overflow: all-ones magnitude plus one
        word(1'b1, 1'b0, 28'hFFFFFFF, 1'b1, 1'b0, 1'b0);
        word(1'b1, 1'b0, 28'd1, 1'b1, 1'b1, 1'b0);
        check("ovf_none_during_add", ovf_cnt, 32'd0);
        word(1'b1, 1'b0, 28'h0, 1'b0, 1'b0, 1'b0);
        check("ovf_mag", {4'd0, cap_mag}, 32'd0);
        check("ovf_sign_eb", {31'd0, cap_sign}, 32'd1);
        check("ovf_AR", {31'd0, ar_mid}, 32'd1);
        check("ovf_AC", {31'd0, AC}, 32'd1);
        check("ovf_pulse_len", ovf_cnt, 32'd29);
        word(1'b1, 1'b0, 28'h0, 1'b0, 1'b0, 1'b0);
        check("ovf_gone", ovf_cnt, 32'd0);
        check("ovf_sign_held", {31'd0, cap_sign}, 32'd1);

        // Asynchronous reset mid-word
        run_word(1'b1, 1'b0, 28'h0, 1'b0, 1'b0, 1'b0, -1, 99, -1, 10);
        check("prerst_AR", {31'd0, AR}, 32'd1);
        check("prerst_AC", {31'd0, AC}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_AR", {31'd0, AR}, 32'd0);
        check("midrst_AC", {31'd0, AC}, 32'd0);
        check("midrst_OVF", {31'd0, AR_OVF}, 32'd0);
        check("midrst_EB", {31'd0, EB_AR}, 32'd0);
        @(posedge CLOCK);
        #1 rst = 1'b0;
        word(1'b1, 1'b0, 28'h0, 1'b0, 1'b0, 1'b0);
        check("postrst_mag", {4'd0, cap_mag}, 32'd0);
        check("postrst_sign", {31'd0, cap_sign}, 32'd0);

        // AA toggled mid-word: copy stays copy, add stays add
        word(1'b1, 1'b0, 28'h0000100, 1'b1, 1'b0, 1'b0);
        run_word(1'b1, 1'b0, 28'h1234567, 1'b1, 1'b0, 1'b0, 10, 99, -1, 29);
        word(1'b1, 1'b0, 28'h0, 1'b0, 1'b0, 1'b0);
        check("aaflip_copy", {4'd0, cap_mag}, 32'h1234567);
        run_word(1'b1, 1'b0, 28'h0000001, 1'b1, 1'b1, 1'b0, 14, 99, -1, 29);
        word(1'b1, 1'b0, 28'h0, 1'b0, 1'b0, 1'b0);
        check("aaflip_add", {4'd0, cap_mag}, 32'h1234568);

        // TS withheld: counter wrap stands in for TS
        word(1'b0, 1'b0, 28'h0, 1'b0, 1'b0, 1'b0);
        check("nots_mag", {4'd0, cap_mag}, 32'h1234568);
        check("nots_sign", {31'd0, cap_sign}, 32'd0);
        word(1'b0, 1'b1, 28'h0000033, 1'b1, 1'b0, 1'b0);
        word(1'b1, 1'b0, 28'h0, 1'b0, 1'b0, 1'b0);
        check("nots_copy_mag", {4'd0, cap_mag}, 32'h33);
        check("nots_copy_sign", {31'd0, cap_sign}, 32'd1);

        // Single-cycle clear removes just the bit in flight (magnitude bit 1)
        word(1'b1, 1'b0, 28'h0000007, 1'b1, 1'b0, 1'b0);
        run_word(1'b1, 1'b0, 28'h0, 1'b0, 1'b0, 1'b0, -1, 2, 2, 29);
        word(1'b1, 1'b0, 28'h0, 1'b0, 1'b0, 1'b0);
        check("clr1_mag", {4'd0, cap_mag}, 32'h5);

        // Full-word clear, landing on a pending sign commit
        word(1'b1, 1'b1, 28'h0000005, 1'b1, 1'b0, 1'b0);
        word(1'b1, 1'b1, 28'hFFFFFFE, 1'b1, 1'b1, 1'b0);
        check("preclr_AC", {31'd0, AC}, 32'd1);
        run_word(1'b1, 1'b0, 28'h0, 1'b0, 1'b0, 1'b0, -1, 0, 28, 29);
        word(1'b1, 1'b0, 28'h0, 1'b0, 1'b0, 1'b0);
        check("clr_mag", {4'd0, cap_mag}, 32'd0);
        check("clr_sign", {31'd0, cap_sign}, 32'd0);
        check("clr_AC", {31'd0, AC}, 32'd0);
        check("clr_AR", {31'd0, ar_mid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
